// File: rtl/layer_1_relu_serializer.sv
// Snapshots the layer-1 accumulators on capture, then streams ReLU + shift/saturate
// requantized activations over valid/ready and pulses done/acc_clear after the last word.
module layer_1_relu_serializer #(
  parameter int SIZE        = 16,
  parameter int NUM_NEURONS = 20,
  parameter int OUT_SIZE    = 8,
  parameter int FRAC_SHIFT  = 4,
  parameter int IDX_W       = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        capture,
  input  logic [NUM_NEURONS*SIZE-1:0] acc_in,
  output logic [OUT_SIZE-1:0]         out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        acc_clear
);

  typedef enum logic {IDLE, STREAM} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [SIZE-1:0]  SAT_MAX  = SIZE'((1 << OUT_SIZE) - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic                   done_q, done_d;
  logic                   load;
  logic signed [SIZE-1:0] snap_q [NUM_NEURONS];
  logic signed [SIZE-1:0] snap_d [NUM_NEURONS];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = STREAM;
          index_d = '0;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // A capture arriving while streaming never reaches here because load is IDLE-only.
  always_comb begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      snap_d[k] = load ? acc_in[k*SIZE +: SIZE] : snap_q[k];
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the snapshot array is reset too, so out_data is defined from the first
  // cycle; it costs a reset mux per bit, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NEURONS; k++) snap_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_NEURONS; k++) snap_q[k] <= snap_d[k];
    end
  end

  logic signed [SIZE-1:0] cur_v;
  logic signed [SIZE-1:0] cur_s;
  logic [OUT_SIZE-1:0]    act;

  always_comb begin
    cur_v = snap_q[index_q];
    cur_s = cur_v >>> FRAC_SHIFT;
    if (cur_v[SIZE-1]) begin
      act = '0;
    end else if ($unsigned(cur_s) > SAT_MAX) begin
      act = '1;
    end else begin
      act = cur_s[OUT_SIZE-1:0];
    end
  end

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_data  = out_valid ? act : '0;
  assign out_index = index_q;
  assign out_last  = out_valid && (index_q == LAST_IDX);
  assign done      = done_q;
  assign acc_clear = done_q;

endmodule

// File: tb/tb_layer_1_relu_serializer.sv
// Scoreboard bench for layer_1_relu_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every transfer.
module tb_layer_1_relu_serializer;

  localparam int SIZE = 16;
  localparam int N    = 20;
  localparam int OUTW = 8;
  localparam int IDXW = 5;

  logic              clk;
  logic              reset;
  logic              capture;
  logic [N*SIZE-1:0] acc_in;
  logic [OUTW-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDXW-1:0]   out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              acc_clear;

  layer_1_relu_serializer #(
    .SIZE(SIZE), .NUM_NEURONS(N), .OUT_SIZE(OUTW), .FRAC_SHIFT(4), .IDX_W(IDXW)
  ) dut (
    .clk(clk), .reset(reset), .capture(capture), .acc_in(acc_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .done(done), .acc_clear(acc_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OUTW-1:0] data;
    int              idx;
  } exp_t;

  exp_t sb[$];
  int   tests     = 0;
  int   fails     = 0;
  int   done_cnt  = 0;
  int   completed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ReLU, floor divide by 2^4, clamp to 255.
  function automatic logic [OUTW-1:0] model(input logic [SIZE-1:0] raw);
    int v;
    int s;
    v = int'($signed(raw));
    if (v < 0) return '0;
    s = v / 16;
    if (s > 255) return 8'hFF;
    return OUTW'(s);
  endfunction

  function automatic logic [N*SIZE-1:0] rand_vec();
    logic [N*SIZE-1:0] v;
    for (int k = 0; k < N; k++) v[k*SIZE +: SIZE] = SIZE'($urandom);
    return v;
  endfunction

  // Monitor: compares transfers, holding, last, busy, and done timing.
  initial begin
    bit              pending_done;
    bit              hold_valid;
    bit              rst_seen;
    logic [OUTW-1:0] hold_data;
    logic [IDXW-1:0] hold_idx;
    exp_t            e;
    pending_done = 0;
    hold_valid   = 0;
    rst_seen     = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending_done = 0;
        hold_valid   = 0;
        rst_seen     = 1;
      end else begin
        if (rst_seen) begin
          check("rst_outputs", {out_data, out_index, out_valid, out_last, busy, done, acc_clear}, 0);
          rst_seen = 0;
        end
        if (done) done_cnt++;
        if (done || acc_clear || pending_done) begin
          check("done_pulse", done, pending_done);
          check("acc_clear_pulse", acc_clear, pending_done);
        end
        pending_done = 0;
        if (hold_valid) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hold_data);
          check("hold_index", out_index, hold_idx);
          hold_valid = 0;
        end
        check("busy_eq_valid", busy, out_valid);
        if (out_valid) check("out_last", out_last, (out_index == IDXW'(N-1)));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_transfer", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_index", out_index, e.idx);
            check("out_data", out_data, e.data);
            if (e.idx == N-1) pending_done = 1;
          end
        end else if (out_valid) begin
          hold_valid = 1;
          hold_data  = out_data;
          hold_idx   = out_index;
        end
      end
    end
  end

  // Capture a sample, push its expected words, and check 1-cycle latency.
  task automatic do_capture(input logic [N*SIZE-1:0] vec);
    exp_t e;
    acc_in  = vec;
    capture = 1'b1;
    for (int k = 0; k < N; k++) begin
      e.data = model(vec[k*SIZE +: SIZE]);
      e.idx  = k;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    capture = 1'b0;
    acc_in  = rand_vec();
    check("first_valid", out_valid, 1);
    check("first_index", out_index, 0);
  endtask

  // mode 0: ready=1; mode 1: random; mode 2: 5-cycle stall at index 3 then toggle.
  task automatic stream_wait(input int mode, input bit cap_hook, input int budget);
    int c;
    int stall;
    bit seen;
    bit hooked;
    bit tog;
    c = 0; stall = 0; seen = 0; hooked = 0; tog = 0;
    while (!seen && c < budget) begin
      capture = 1'b0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall < 5 && (stall > 0 || (out_valid && out_index == 3))) begin
            out_ready = 1'b0;
            stall++;
          end else if (stall >= 5) begin
            tog = ~tog;
            out_ready = tog;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (cap_hook && !hooked && out_valid && out_index == 7) begin
        capture = 1'b1;
        acc_in  = rand_vec();
        hooked  = 1;
      end
      @(posedge clk); #1;
      c++;
      if (done) seen = 1;
    end
    capture = 1'b0;
    check("stream_done", seen, 1);
    if (seen) begin
      completed++;
      check("idle_after_done_valid", out_valid, 0);
      check("idle_after_done_busy", busy, 0);
    end
  endtask

  initial begin
    logic [N*SIZE-1:0] v;
    logic [SIZE-1:0]   corners [7];
    int c;
    corners[0] = 16'h0123; corners[1] = 16'h8000; corners[2] = 16'hFFF0;
    corners[3] = 16'h000F; corners[4] = 16'h0FF0; corners[5] = 16'h1000;
    corners[6] = 16'h7FFF;

    reset = 1'b1; capture = 1'b0; out_ready = 1'b0; acc_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Basic stream: neuron k = k<<4.
    for (int k = 0; k < N; k++) v[k*SIZE +: SIZE] = SIZE'(k << 4);
    out_ready = 1'b1;
    do_capture(v);
    stream_wait(0, 0, 200);

    // Arithmetic corners in neurons 0..6, random elsewhere.
    repeat (2) @(posedge clk); #1;
    v = rand_vec();
    for (int k = 0; k < 7; k++) v[k*SIZE +: SIZE] = corners[k];
    do_capture(v);
    stream_wait(0, 0, 200);

    // Backpressure pattern.
    repeat (2) @(posedge clk); #1;
    do_capture(rand_vec());
    stream_wait(2, 0, 400);

    // Capture while busy: snapshot must not change.
    repeat (2) @(posedge clk); #1;
    do_capture(rand_vec());
    stream_wait(0, 1, 200);

    // Reset mid-stream at index 10.
    repeat (2) @(posedge clk); #1;
    do_capture(rand_vec());
    out_ready = 1'b1;
    c = 0;
    while (out_index != 10 && c < 100) begin
      @(posedge clk); #1; c++;
    end
    check("reached_index_10", out_index, 10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_done", {done, acc_clear}, 0);
    repeat (3) @(posedge clk); #1;
    do_capture(rand_vec());
    stream_wait(1, 0, 400);

    // Back-to-back: capture in the done cycle.
    do_capture(rand_vec());
    stream_wait(1, 0, 400);
    do_capture(rand_vec());
    stream_wait(0, 0, 200);

    // Random samples with random backpressure and idle gaps.
    for (int s = 0; s < 6; s++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_capture(rand_vec());
      stream_wait(1, 0, 400);
    end

    repeat (4) @(posedge clk); #1;
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_cnt, completed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_1_relu_serializer.md
Name: layer_1_relu_serializer

Overview:
- Consumer for the 20 layer-1 bias-add accumulators.
- On a capture strobe, snapshots all NUM_NEURONS signed accumulator values. It then applies ReLU and shift/saturate requantization to OUT_SIZE-bit unsigned activations.
- Streams the activations, one per transfer, to the layer-2 input over a valid/ready handshake.
- After the last transfer it pulses acc_clear so the upstream accumulators can be re-seeded with their biases for the next sample.

Parameters:
- SIZE, 16, width of each signed accumulator value (two's complement).
- NUM_NEURONS, 20, number of accumulator values captured and streamed.
- OUT_SIZE, 8, width of each unsigned output activation.
- FRAC_SHIFT, 4, arithmetic right shift applied to the accumulator value before saturation.
- IDX_W, 5, width of the index counter; must satisfy 2^IDX_W >= NUM_NEURONS.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- capture  input  1  single-cycle strobe; accumulators are final (driven from the accumulator done).
- acc_in  input  NUM_NEURONS*SIZE  flattened accumulator values; neuron k occupies bits [k*SIZE +: SIZE].
- out_data  output  OUT_SIZE  activation for the current index.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  downstream accepts the current word.
- out_index  output  IDX_W  neuron number of the current word, 0..NUM_NEURONS-1.
- out_last  output  1  high with out_valid when out_index == NUM_NEURONS-1.
- busy  output  1  high while a sample is held or streaming.
- done  output  1  one-cycle pulse after the final transfer.
- acc_clear  output  1  one-cycle pulse, coincident with done, for the upstream accumulator reset.

Behaviour:
- Reset (synchronous): state=IDLE, index=0, all snapshot registers=0, and every output = 0 (out_data, out_valid, out_index, out_last, busy, done, acc_clear).
- States:
  - IDLE: out_valid=0, busy=0.
  - STREAM: out_valid=1, busy=1.
- IDLE -> STREAM:
  - Triggered by capture=1 in IDLE.
  - All NUM_NEURONS values of acc_in are registered on that edge, and index is set to 0.
  - out_valid rises the following cycle, so capture-to-first-valid latency is 1 cycle.
- capture while in STREAM: ignored; the snapshot is not modified.
- Transfer: occurs on any edge with out_valid=1 and out_ready=1.
- Holding rule: while out_valid=1 and out_ready=0, out_data, out_index and out_last stay stable.
- out_valid never drops without a transfer, except on reset.
- Transfer with index < NUM_NEURONS-1: index increments and the next word is presented the next cycle. Back-to-back transfers give one word per cycle.
- Transfer with index == NUM_NEURONS-1: next cycle is state=IDLE, index=0, out_valid=0, done=1, acc_clear=1, each high for exactly one cycle.
- capture in the done cycle: accepted. IDLE is already entered, so a new stream can start with one idle cycle between samples.
- Requantization (combinational from the snapshot at the current index, registered or not at implementer's choice, provided the latency above holds). With v = signed snapshot[index]:
  - v < 0 -> 0 (ReLU).
  - Otherwise s = v >>> FRAC_SHIFT; if s > 2^OUT_SIZE-1, out_data = 2^OUT_SIZE-1 (saturate); else out_data = s[OUT_SIZE-1:0].
- out_last = out_valid && (index == NUM_NEURONS-1).
- Reset mid-stream: abort immediately. The next cycle shows reset values, and done/acc_clear are not pulsed.
- reset and capture in the same cycle: reset wins.

Test Plan:
- Basic stream:
  - Stimulus: acc_in neuron k = k<<4 for k=0..19, out_ready held 1, capture pulse at cycle 0.
  - Required: out_valid high cycles 1..20; out_data = 0,1,...,19 with out_index matching; out_last only at index 19; done=acc_clear=1 at cycle 21 only; busy low at cycle 21.
- Arithmetic corners (one capture, out_ready=1), expected out_data per neuron:
  - 0x0123 -> 0x12
  - 0x8000 -> 0x00
  - 0xFFF0 -> 0x00
  - 0x000F -> 0x00
  - 0x0FF0 -> 0xFF
  - 0x1000 -> 0xFF (saturated)
  - 0x7FFF -> 0xFF
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles at index 3, then toggled 1/0 every cycle.
  - Required: out_data/out_index frozen while stalled; every value transferred exactly once, in order; done pulses one cycle after the 20th transfer.
- Capture while busy:
  - Stimulus: capture plus changed acc_in at index 7.
  - Required: stream continues with original snapshot values; no restart; exactly one done.
- Reset mid-stream:
  - Stimulus: reset at index 10.
  - Required: next cycle all outputs 0, no done/acc_clear pulse. A subsequent capture streams from index 0 with the new acc_in.
- Back-to-back samples:
  - Stimulus: capture asserted in the done cycle.
  - Required: new stream starts next cycle at index 0 with the new snapshot; acc_clear pulsed exactly once per completed sample.
